// File: rtl/fish_sprite_engine.sv
// Single-fish sprite engine: spawn/swim/hook position FSM plus a two-stage
// pixel pipeline that reads a synchronous sprite ROM and keys out KEY pixels.
module fish_sprite_engine #(
  parameter int          SPR_W = 40,
  parameter int          SPR_H = 33,
  parameter int          SCALE = 2,
  parameter logic [11:0] KEY   = 12'h352,
  parameter int          H_MAX = 640,
  parameter int          SPEED = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        frame_tick,
  input  logic        spawn,
  input  logic [9:0]  spawn_h,
  input  logic [9:0]  spawn_v,
  input  logic        spawn_dir,
  input  logic        catch,
  output logic [10:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic        background,
  output logic [11:0] vga,
  output logic [9:0]  fish_h,
  output logic [9:0]  fish_v,
  output logic [1:0]  fish_way,
  output logic        fish_appear,
  output logic        done
);
  // state  | meaning
  // IDLE   | no fish; waiting for spawn
  // SWIM   | fish bounces horizontally between SPR_W and H_MAX
  // HOOKED | fish rises SPEED rows per frame until it leaves the top
  typedef enum logic [1:0] {IDLE = 2'd0, SWIM = 2'd1, HOOKED = 2'd2} state_t;

  localparam logic [9:0]  H_LO    = 10'(SPR_W);
  localparam logic [9:0]  H_HI    = 10'(H_MAX);
  localparam logic [9:0]  STEP    = 10'(SPEED);
  localparam logic [9:0]  TURN_L  = 10'(SPR_W + SPEED);
  localparam logic [9:0]  TURN_R  = 10'(H_MAX - SPEED);
  localparam logic [9:0]  EXIT_V  = 10'(2 * SPEED);
  localparam logic [9:0]  COL_LIM = 10'(SPR_W - 1);
  localparam logic [9:0]  ROW_LIM = 10'(SPR_H - 1);
  localparam logic [9:0]  UP_LIM  = 10'(SCALE * SPR_W - 1);
  localparam logic [10:0] STRIDE  = 11'(SPR_W);
  localparam int          SCALE_SH = $clog2(SCALE);

  state_t      state_q, state_d;
  logic [9:0]  fish_h_q, fish_h_d, fish_v_q, fish_v_d;
  logic [1:0]  fish_way_q, fish_way_d;
  logic        done_q, done_d;
  logic        hit_q, hit_d;
  logic        background_q, background_d;
  logic [11:0] vga_q, vga_d;
  logic [9:0]  dx_fwd, dx_rev, dy;

  // Boundary checks use the post-move position: reaching a wall turns the
  // fish on that same tick, and a hooked fish exits once within one step of the top.
  always_comb begin
    state_d    = state_q;
    fish_h_d   = fish_h_q;
    fish_v_d   = fish_v_q;
    fish_way_d = fish_way_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (spawn) begin
        state_d    = SWIM;
        fish_h_d   = (spawn_h < H_LO) ? H_LO : ((spawn_h > H_HI) ? H_HI : spawn_h);
        fish_v_d   = spawn_v;
        fish_way_d = {1'b0, spawn_dir};
      end
      SWIM: if (catch) begin
        state_d    = HOOKED;
        fish_way_d = 2'd2;
      end else if (frame_tick) begin
        if (fish_way_q == 2'd0) begin
          if (fish_h_q <= TURN_L) begin
            fish_h_d   = H_LO;
            fish_way_d = 2'd1;
          end else fish_h_d = fish_h_q - STEP;
        end else begin
          if (fish_h_q >= TURN_R) begin
            fish_h_d   = H_HI;
            fish_way_d = 2'd0;
          end else fish_h_d = fish_h_q + STEP;
        end
      end
      HOOKED: if (frame_tick) begin
        if (fish_v_q <= EXIT_V) begin
          state_d  = IDLE;
          fish_v_d = '0;
          done_d   = 1'b1;
        end else fish_v_d = fish_v_q - STEP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dx_fwd   = h_cnt + H_LO - fish_h_q;
    dx_rev   = fish_h_q - h_cnt;
    dy       = v_cnt - fish_v_q;
    hit_d    = 1'b0;
    rom_addr = '0;
    if (state_q != IDLE) begin
      case (fish_way_q)
        2'd0: if (dx_fwd <= COL_LIM && dy <= ROW_LIM) begin
          hit_d    = 1'b1;
          rom_addr = 11'(dy) * STRIDE + 11'(dx_fwd);
        end
        2'd1: if (dx_fwd <= COL_LIM && dy <= ROW_LIM) begin
          hit_d    = 1'b1;
          rom_addr = 11'(dy) * STRIDE + 11'(dx_rev - 10'd1);
        end
        2'd2: if (dx_rev <= ROW_LIM && dy <= UP_LIM) begin
          hit_d    = 1'b1;
          rom_addr = 11'(dx_rev) * STRIDE + 11'(dy >> SCALE_SH);
        end
        default: hit_d = 1'b0;
      endcase
    end
    background_d = !(hit_q && rom_data != KEY);
    vga_d        = background_d ? 12'h000 : rom_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fish_h_q     <= '0;
      fish_v_q     <= '0;
      fish_way_q   <= 2'd0;
      done_q       <= 1'b0;
      hit_q        <= 1'b0;
      background_q <= 1'b1;
      vga_q        <= 12'h000;
    end else begin
      state_q      <= state_d;
      fish_h_q     <= fish_h_d;
      fish_v_q     <= fish_v_d;
      fish_way_q   <= fish_way_d;
      done_q       <= done_d;
      hit_q        <= hit_d;
      background_q <= background_d;
      vga_q        <= vga_d;
    end
  end

  assign fish_h      = fish_h_q;
  assign fish_v      = fish_v_q;
  assign fish_way    = fish_way_q;
  assign fish_appear = (state_q != IDLE);
  assign done        = done_q;
  assign background  = background_q;
  assign vga         = vga_q;

endmodule

// File: tb/tb_fish_sprite_engine.sv
// Self-checking bench for fish_sprite_engine: directed corner scenarios plus
// randomized traffic compared against a position/pixel reference model.
module tb_fish_sprite_engine;
  localparam int          SPR_W = 40;
  localparam int          SPR_H = 33;
  localparam int          SCALE = 2;
  localparam logic [11:0] KEY   = 12'h352;
  localparam int          H_MAX = 640;
  localparam int          SPEED = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  h_cnt = '0, v_cnt = '0, spawn_h = '0, spawn_v = '0;
  logic        frame_tick = 1'b0, spawn = 1'b0, spawn_dir = 1'b0, catch = 1'b0;
  logic [10:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic        background, fish_appear, done;
  logic [11:0] vga;
  logic [9:0]  fish_h, fish_v;
  logic [1:0]  fish_way;

  logic [11:0] rom_mem [0:2047];
  int n_chk = 0, n_err = 0;

  // reference model: phase 0 = no fish, 1 = swimming, 2 = hooked
  int m_phase, m_h, m_v, m_way;
  bit m_done;
  bit prev_bg, exp_bg;
  logic [11:0] prev_vga, exp_vga;

  fish_sprite_engine #(.SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE(SCALE), .KEY(KEY),
                       .H_MAX(H_MAX), .SPEED(SPEED)) dut (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_tick(frame_tick),
    .spawn(spawn), .spawn_h(spawn_h), .spawn_v(spawn_v), .spawn_dir(spawn_dir),
    .catch(catch), .rom_addr(rom_addr), .rom_data(rom_data), .background(background),
    .vga(vga), .fish_h(fish_h), .fish_v(fish_v), .fish_way(fish_way),
    .fish_appear(fish_appear), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wrap10(input int x);
    return ((x % 1024) + 1024) % 1024;
  endfunction

  function automatic int exp_addr(input int h, input int v, output bit hit);
    int dy, col;
    hit = 0;
    if (m_phase == 0) return 0;
    dy = wrap10(v - m_v);
    if (m_way == 2) begin
      col = wrap10(m_h - h);
      if (col < SPR_H && dy < SCALE * SPR_W) begin
        hit = 1;
        return col * SPR_W + dy / SCALE;
      end
    end else begin
      col = wrap10(h - (m_h - SPR_W));
      if (col < SPR_W && dy < SPR_H) begin
        hit = 1;
        return (m_way == 0) ? dy * SPR_W + col : dy * SPR_W + (SPR_W - 1 - col);
      end
    end
    return 0;
  endfunction

  task automatic model_step();
    int nh, nv;
    m_done = 0;
    if (m_phase == 0) begin
      if (spawn) begin
        m_phase = 1;
        m_h = (int'(spawn_h) < SPR_W) ? SPR_W : ((int'(spawn_h) > H_MAX) ? H_MAX : int'(spawn_h));
        m_v = int'(spawn_v);
        m_way = int'(spawn_dir);
      end
    end else if (m_phase == 1) begin
      if (catch) begin
        m_phase = 2;
        m_way = 2;
      end else if (frame_tick) begin
        nh = (m_way == 0) ? m_h - SPEED : m_h + SPEED;
        if (m_way == 0 && nh <= SPR_W) begin m_h = SPR_W; m_way = 1; end
        else if (m_way == 1 && nh >= H_MAX) begin m_h = H_MAX; m_way = 0; end
        else m_h = nh;
      end
    end else if (frame_tick) begin
      nv = m_v - SPEED;
      if (nv <= SPEED) begin m_phase = 0; m_v = 0; m_done = 1; end
      else m_v = nv;
    end
  endtask

  task automatic check_outputs();
    chk("fish_h", 32'(fish_h), 32'(m_h));
    chk("fish_v", 32'(fish_v), 32'(m_v));
    chk("fish_way", 32'(fish_way), 32'(m_way));
    chk("fish_appear", 32'(fish_appear), 32'(m_phase != 0));
    chk("done", 32'(done), 32'(m_done));
    chk("background", 32'(background), 32'(exp_bg));
    chk("vga", 32'(vga), 32'(exp_vga));
  endtask

  // one clock: inputs were set at the preceding negedge
  task automatic tick();
    int a;
    bit hit;
    logic [11:0] word;
    #1;
    a = exp_addr(int'(h_cnt), int'(v_cnt), hit);
    chk("rom_addr", 32'(rom_addr), 32'(a));
    word = rom_mem[a];
    @(posedge clk);
    exp_bg = prev_bg;
    exp_vga = prev_vga;
    prev_bg = !(hit && word != KEY);
    prev_vga = prev_bg ? 12'h000 : word;
    model_step();
    @(negedge clk);
    check_outputs();
    spawn = 0; catch = 0; frame_tick = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_fish_h", 32'(fish_h), 32'd0);
    chk("rst_fish_v", 32'(fish_v), 32'd0);
    chk("rst_fish_way", 32'(fish_way), 32'd0);
    chk("rst_appear", 32'(fish_appear), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_background", 32'(background), 32'd1);
    chk("rst_vga", 32'(vga), 32'd0);
    m_phase = 0; m_h = 0; m_v = 0; m_way = 0; m_done = 0;
    prev_bg = 1; prev_vga = 12'h000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic do_spawn(input int h, input int v, input bit dir);
    spawn = 1; spawn_h = 10'(h); spawn_v = 10'(v); spawn_dir = dir;
    tick();
  endtask

  task automatic sweep(input int v, input int h0, input int h1);
    v_cnt = 10'(v);
    for (int h = h0; h <= h1; h++) begin
      h_cnt = 10'(h);
      tick();
    end
    h_cnt = 10'd1000;
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
    #2;
    do_reset();

    // left-swimming sprite sweep, then mirrored sweep including one column past the edge
    do_spawn(300, 100, 0);
    sweep(100, 260, 299);
    do_reset();
    do_spawn(300, 100, 1);
    sweep(100, 260, 300);
    sweep(120, 255, 305);

    // wall bounce at the left edge
    do_reset();
    do_spawn(42, 50, 0);
    frame_tick = 1; tick();
    chk("bounce_h", 32'(fish_h), 32'd40);
    chk("bounce_way", 32'(fish_way), 32'd1);
    frame_tick = 1; tick();
    chk("bounce_h2", 32'(fish_h), 32'd42);
    do_spawn(500, 60, 0);
    chk("spawn_ignored_h", 32'(fish_h), 32'd42);

    // catch wins over a simultaneous frame tick, then hooked rendering
    do_reset();
    do_spawn(200, 50, 1);
    catch = 1; frame_tick = 1; tick();
    chk("catch_h", 32'(fish_h), 32'd200);
    chk("catch_way", 32'(fish_way), 32'd2);
    sweep(60, 160, 205);
    sweep(129, 165, 201);
    sweep(130, 165, 201);

    // hooked fish leaves the top: done for exactly one clock
    do_reset();
    do_spawn(100, 3, 0);
    catch = 1; tick();
    frame_tick = 1; tick();
    chk("exit_done", 32'(done), 32'd1);
    chk("exit_appear", 32'(fish_appear), 32'd0);
    tick();
    chk("exit_done_gone", 32'(done), 32'd0);

    // reset while hooked, then a fresh spawn with clamping
    do_spawn(900, 200, 1);
    chk("clamp_hi", 32'(fish_h), 32'd640);
    catch = 1; tick();
    do_reset();
    do_spawn(5, 20, 0);
    chk("clamp_lo", 32'(fish_h), 32'd40);
    chk("respawn_appear", 32'(fish_appear), 32'd1);

    for (int n = 0; n < 5000; n++) begin
      spawn      = ($urandom_range(0, 39) == 0);
      spawn_h    = 10'($urandom_range(0, 1023));
      spawn_v    = 10'($urandom_range(0, 400));
      spawn_dir  = 1'($urandom_range(0, 1));
      catch      = ($urandom_range(0, 79) == 0);
      frame_tick = ($urandom_range(0, 9) == 0);
      h_cnt      = 10'(m_h - 50 + int'($urandom_range(0, 100)));
      v_cnt      = 10'(m_v - 5 + int'($urandom_range(0, 90)));
      tick();
      if (n == 2500) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
